// File: rtl/evm_ballot_conditioner.sv
// Ballot front-end: synchronizes and debounces the three candidate buttons,
// runs the one-ballot-per-arming FSM and issues registered vote/error pulses.
module evm_ballot_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_candidate,
  input  logic       candidate_ready,
  input  logic       voting_session_done,
  output logic       vote_candidate_1,
  output logic       vote_candidate_2,
  output logic       vote_candidate_3,
  output logic       multi_press_error,
  output logic       armed,
  output logic       locked,
  output logic [7:0] ballots_issued
);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_RELEASE, LOCKED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [2:0] sync_p0, sync_p1;
  logic [2:0] deb_p2, deb_next;
  logic [7:0] cnt_p2 [3];
  logic [7:0] cnt_next [3];
  logic [2:0] press_p3;
  logic       press_any;
  state_t     state, state_next;
  logic [2:0] vote_next;
  logic       err_next;
  logic       count_inc;

  // Ballot counter saturates at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] ones3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Stage p0/p1: two-flop synchronizer on the raw asynchronous buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_candidate;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce update: flip a button once it has disagreed for DEBOUNCE_CYCLES samples.
  always_comb begin
    deb_next = deb_p2;
    for (int i = 0; i < 3; i++) begin
      cnt_next[i] = 8'd0;
      if (sync_p1[i] != deb_p2[i]) begin
        if (cnt_p2[i] == CNT_LAST) begin
          deb_next[i] = sync_p1[i];
          cnt_next[i] = 8'd0;
        end else begin
          cnt_next[i] = cnt_p2[i] + 8'd1;
        end
      end
    end
  end

  // Stage p2/p3: debounced levels and the rising-edge press flags taken on the flip edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_p2   <= '0;
      press_p3 <= '0;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= 8'd0;
    end else begin
      deb_p2   <= deb_next;
      press_p3 <= deb_next & ~deb_p2;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= cnt_next[i];
    end
  end

  assign press_any = |press_p3;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and ballot decision; session close overrides any decision.
  always_comb begin
    state_next = state;
    vote_next  = 3'b000;
    err_next   = 1'b0;
    count_inc  = 1'b0;
    if (voting_session_done) begin
      state_next = LOCKED;
    end else begin
      case (state)
        IDLE: begin
          if (candidate_ready) state_next = ARMED;
        end
        ARMED: begin
          if (press_any) begin
            state_next = WAIT_RELEASE;
            if (ones3(deb_p2) == 2'd1) begin
              vote_next = deb_p2;
              count_inc = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        WAIT_RELEASE: begin
          if (deb_p2 == 3'b000) state_next = IDLE;
        end
        default: state_next = LOCKED;
      endcase
    end
  end

  // Stage p4: registered pulses and ballot count.
  always_ff @(posedge clk) begin
    if (rst) begin
      vote_candidate_1  <= 1'b0;
      vote_candidate_2  <= 1'b0;
      vote_candidate_3  <= 1'b0;
      multi_press_error <= 1'b0;
      ballots_issued    <= 8'd0;
    end else begin
      vote_candidate_1  <= vote_next[0];
      vote_candidate_2  <= vote_next[1];
      vote_candidate_3  <= vote_next[2];
      multi_press_error <= err_next;
      if (count_inc) ballots_issued <= sat_inc(ballots_issued);
    end
  end

  assign armed  = (state == ARMED);
  assign locked = (state == LOCKED);

endmodule

// File: doc/evm_ballot_conditioner.md
EVM_BALLOT_CONDITIONER -- requirements
Module: evm_ballot_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, range 2..255: consecutive synchronized samples needed to accept a button level change.
REQ-002 SHALL have ports clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset. One clock, reset synchronous and active-high.
REQ-003 SHALL have btn_candidate  in  3  raw asynchronous candidate buttons, bit0 = candidate 1, active-high.
REQ-004 SHALL have candidate_ready  in  1  officer arms one ballot, level.
REQ-005 SHALL have voting_session_done  in  1  session closed, level.
REQ-006 SHALL have vote_candidate_1, vote_candidate_2, vote_candidate_3  out  1 each  single-cycle accepted-vote pulses to the EVM core.
REQ-007 SHALL have multi_press_error  out  1  single-cycle pulse, ballot rejected due to multiple buttons.
REQ-008 SHALL have armed  out  1  high while a ballot may be cast (state ARMED).
REQ-009 SHALL have locked  out  1  high once session closed.
REQ-010 SHALL have ballots_issued  out  8  count of accepted votes.

Function
REQ-011 Each btn_candidate bit SHALL pass a 2-flop synchronizer; downstream logic uses only synchronized values.
REQ-012 Per button, a debounce counter SHALL increment each cycle the synchronized value differs from the debounced value, clear to 0 when equal, and the debounced value SHALL flip on the DEBOUNCE_CYCLES-th consecutive differing sample (counter cleared same edge).
REQ-013 A press event SHALL be a debounced 0->1 transition of any bit, detected the same cycle the debounced value flips.
REQ-014 FSM states SHALL be IDLE, ARMED, WAIT_RELEASE, LOCKED; reset state IDLE.
REQ-015 IDLE: candidate_ready high -> ARMED next edge; button activity in IDLE SHALL be ignored.
REQ-016 ARMED: press event with exactly one debounced bit high (after update) SHALL emit a one-cycle pulse on the matching vote_candidate_N, increment ballots_issued, go WAIT_RELEASE.
REQ-017 ARMED: press event with two or more debounced bits high (simultaneous flips or a second press while another held) SHALL emit one multi_press_error pulse, no vote, go WAIT_RELEASE.
REQ-018 WAIT_RELEASE: all three debounced bits low -> IDLE; no further pulses in this state.
REQ-019 A ballot SHALL yield at most one vote pulse; a new ballot requires return to IDLE and candidate_ready high.
REQ-020 voting_session_done high in any state SHALL force LOCKED next edge, with priority over all other transitions; a vote decision in that same cycle SHALL be discarded (no pulse, no count).
REQ-021 LOCKED SHALL be exited only by rst; no pulses while LOCKED.
REQ-022 Outputs SHALL be registered: vote/error pulse high for exactly the cycle after the edge that registers the decision.
REQ-023 Latency: button stable high from before edge k, ARMED, others low -> vote pulse registered at edge k+2+DEBOUNCE_CYCLES.
REQ-024 ballots_issued SHALL saturate at 255 (no wrap); pulses still issued at saturation.
REQ-025 Bounces shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.

Reset
REQ-026 rst SHALL clear synchronizers, debounce counters, debounced values, ballots_issued to 0, FSM to IDLE; all outputs 0 next edge.
REQ-027 rst asserted mid-debounce or mid-ballot SHALL abandon it; no pulse issued during or on the edge after reset.
REQ-028 A button held through reset release SHALL be debounced afresh and, if state is ARMED, counted as a press event.

Verification
REQ-029 DEBOUNCE_CYCLES=4, candidate_ready=1 then btn_candidate=3'b010 held -> one vote_candidate_2 pulse 6 cycles after first sampled high, ballots_issued=1, state WAIT_RELEASE; release -> IDLE.
REQ-030 ARMED, btn_candidate toggles 1-cycle glitches for 20 cycles -> no pulses, armed stays 1.
REQ-031 ARMED, btn_candidate=3'b101 same cycle -> single multi_press_error pulse, no vote, ballots_issued unchanged.
REQ-032 Press bit0 held in WAIT_RELEASE, re-press bit0 without candidate_ready -> no second pulse.
REQ-033 voting_session_done asserted same cycle a vote decision would register -> no pulse, locked=1, stays LOCKED until rst.
REQ-034 256 valid ballots -> ballots_issued=255, 256th vote pulse still emitted.
